pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register (e.g. EX->MEM) carrying N_WORDS data words plus a

---
 rtl/cpu_pipe_pkg.sv | 19 +
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU inter-stage pipeline registers: control bundle bit map,
// control bundle type and the occupancy state of a skid-buffered stage.
package cpu_pipe_pkg;

  localparam int CTRL_WMEM = 0;
  localparam int CTRL_RMEM = 1;
  localparam int CTRL_WREG = 2;
  localparam int CTRL_IMM  = 3;
  localparam int CTRL_BITS = 4;

  typedef logic [CTRL_BITS-1:0] ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer,
// synchronous flush of held ops and a saturating stall counter.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int N_WORDS        = 2,
  parameter int CTRL_W         = 4,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_WORDS*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]         in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_WORDS*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam int DW = N_WORDS * DATA_W;

  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [DW-1:0]          main_data_q, main_data_d;
  logic [DW-1:0]          skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  state_e                 state;
  logic                   accept;
  logic                   emit;

  // Skid only ever fills behind a valid main entry, so the two valid bits encode the state.
  always_comb begin
    state = ST_EMPTY;
    if (skid_valid_q)      state = ST_TWO;
    else if (main_valid_q) state = ST_ONE;
  end

  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    stall_cnt_d  = stall_cnt_q;

    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end
      end
      ST_ONE: begin
        if (emit && accept) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (emit) begin
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_ctrl_d  = in_ctrl;
        end
      end
      ST_TWO: begin
        if (emit) begin
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase

    // Flush drops any same-cycle accept; zeroed ctrl keeps a killed op from writing anything.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
    end

    if (in_valid && !in_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = ((ZERO_ON_BUBBLE != 0) && !main_valid_q) ? '0 : main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush and
// stall-counter saturation, each scenario checking against hand-computed values.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int NW     = 2;
  localparam int CW     = 4;
  localparam int SCW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [NW*DATA_W-1:0] in_data;
  logic [CW-1:0]     in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [NW*DATA_W-1:0] out_data;
  logic [CW-1:0]     out_ctrl;
  logic [SCW-1:0]    stall_cnt;

  int nCompared   = 0;
  int nMismatched = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .N_WORDS(NW), .CTRL_W(CW), .ZERO_ON_BUBBLE(1), .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Op k carries word1 = k and word0 = k+100.
  function automatic logic [NW*DATA_W-1:0] mk(input int k);
    return {32'(k), 32'(k + 100)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkD(input string name, input logic [NW*DATA_W-1:0] act,
                      input logic [NW*DATA_W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkC(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkS(input string name, input logic [SCW-1:0] act, input logic [SCW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input int k, input logic [CW-1:0] c);
    in_valid = 1'b1; in_data = mk(k); in_ctrl = c;
    #1;
    chk1("push_in_ready", in_ready, 1'b1);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = mk(7); in_ctrl = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkC("rst_out_ctrl", out_ctrl, 4'h0);
    end
    chkS("rst_stall_cnt", stall_cnt, 4'd0);
    chkD("rst_out_data", out_data, '0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(k, 4'(k + 1));
      chk1("stream_out_valid", out_valid, 1'b1);
      chkD("stream_out_data", out_data, mk(k));
      chkC("stream_out_ctrl", out_ctrl, 4'(k + 1));
    end
    in_valid = 1'b0;
    step();
    chk1("stream_drain_valid", out_valid, 1'b0);
    chkC("stream_drain_ctrl", out_ctrl, 4'h0);
    chkD("stream_drain_data", out_data, '0);
  endtask

  task automatic test_back_pressure();
    apply_reset();
    push(1, 4'h1);
    push(2, 4'h2);
    chkD("bp_main_A", out_data, mk(1));
    in_valid = 1'b1; in_data = mk(3); in_ctrl = 4'h3;
    #1;
    chk1("bp_C_blocked", in_ready, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chkS("bp_stall_cnt", stall_cnt, 4'(i));
    end
    chk1("bp_hold_valid", out_valid, 1'b1);
    chkD("bp_hold_A", out_data, mk(1));
    out_ready = 1'b1;
    #1;
    chk1("bp_release_ready", in_ready, 1'b0);
    step();
    chkD("bp_out_B", out_data, mk(2));
    chkS("bp_stall_final", stall_cnt, 4'd4);
    chk1("bp_ready_after_shift", in_ready, 1'b1);
    step();
    chkD("bp_out_C", out_data, mk(3));
    chkC("bp_ctrl_C", out_ctrl, 4'h3);
    in_valid = 1'b0;
    step();
    chk1("bp_empty", out_valid, 1'b0);
    chkS("bp_stall_kept", stall_cnt, 4'd4);
  endtask

  task automatic test_flush_two();
    apply_reset();
    push(10, 4'b0101);
    push(11, 4'b0101);
    chk1("fl2_full", in_ready, 1'b0);
    chkC("fl2_ctrl_before", out_ctrl, 4'b0101);
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("fl2_out_valid", out_valid, 1'b0);
    chkC("fl2_out_ctrl", out_ctrl, 4'h0);
    chkD("fl2_out_data", out_data, '0);
    chk1("fl2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("fl2_no_emit", out_valid, 1'b0);
    end
  endtask

  task automatic test_flush_emit();
    apply_reset();
    out_ready = 1'b1;
    push(20, 4'b0110);
    chkD("fle_main_A", out_data, mk(20));
    flush = 1'b1; in_valid = 1'b1; in_data = mk(21); in_ctrl = 4'b0100;
    #1;
    chk1("fle_emit_valid", out_valid, 1'b1);
    chkD("fle_emit_data", out_data, mk(20));
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk1("fle_empty", out_valid, 1'b0);
    step();
    chk1("fle_dropped", out_valid, 1'b0);
    chkC("fle_ctrl", out_ctrl, 4'h0);
    chkS("fle_stall", stall_cnt, 4'd0);
  endtask

  task automatic test_stall_saturate();
    apply_reset();
    push(30, 4'h1);
    push(31, 4'h2);
    in_valid = 1'b1; in_data = mk(32); in_ctrl = 4'h3;
    for (int i = 0; i < 5; i++) step();
    chkS("sat_count5", stall_cnt, 4'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chkS("sat_flush_keeps", stall_cnt, 4'd5);
    chk1("sat_flush_empty", out_valid, 1'b0);
    step();
    step();
    chk1("sat_refilled", in_ready, 1'b0);
    chkS("sat_no_count_on_accept", stall_cnt, 4'd5);
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 10) chkS("sat_reach", stall_cnt, 4'd15);
    end
    chkS("sat_hold", stall_cnt, 4'd15);
    rst = 1'b1;
    step();
    chkS("sat_rst_cnt", stall_cnt, 4'd0);
    chk1("sat_rst_valid", out_valid, 1'b0);
    chkC("sat_rst_ctrl", out_ctrl, 4'h0);
    chkD("sat_rst_data", out_data, '0);
    chk1("sat_rst_ready", in_ready, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk1("sat_release_ready", in_ready, 1'b1);
  endtask

  initial begin
    $display("[TB] starting pipe_stage_skid bench");
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_two();
    test_flush_emit();
    test_stall_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
